// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and decode helpers for the RV32M multiply/divide unit.
//   muldiv_op_e    funct3 encodings MUL..REMU (0..7)
//   muldiv_state_e FSM states IDLE/CALC/DONE
//   is_div / is_rem / is_signed_a / is_signed_b  operation decode helpers
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_e;

  function automatic logic is_div(muldiv_op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic is_rem(muldiv_op_e op);
    return op inside {OP_REM, OP_REMU};
  endfunction

  // MUL is treated as unsigned: the low half of the product is sign-agnostic.
  function automatic logic is_signed_a(muldiv_op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_signed_b(muldiv_op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: issue/result bundle between the core and the multiply/divide unit.
//   master (core)  drives start, op, rs1_data, rs2_data, rd_in, flush
//                  receives busy, done, result, rd_out, we_out
//   slave  (unit)  the mirror image
interface muldiv_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5
);
  logic                     start;
  logic [2:0]               op;
  logic [DATA_WIDTH-1:0]    rs1_data;
  logic [DATA_WIDTH-1:0]    rs2_data;
  logic [ADDRESS_WIDTH-1:0] rd_in;
  logic                     flush;
  logic                     busy;
  logic                     done;
  logic [DATA_WIDTH-1:0]    result;
  logic [ADDRESS_WIDTH-1:0] rd_out;
  logic                     we_out;

  modport master (
    output start, op, rs1_data, rs2_data, rd_in, flush,
    input  busy, done, result, rd_out, we_out
  );

  modport slave (
    input  start, op, rs1_data, rs2_data, rd_in, flush,
    output busy, done, result, rd_out, we_out
  );
endinterface

// File: rtl/muldiv_div_iter.sv
// muldiv_div_iter: restoring divider datapath, one quotient bit per step.
//   clk, rst          clock, async active-high reset
//   load              capture dividend, clear partial remainder
//   step              advance one restoring iteration
//   dividend, divisor unsigned magnitudes (divisor held stable by the caller)
//   quotient          quotient value after the current step
//   remainder         remainder value after the current step
// The post-step values are exposed so the caller can fold the final step
// and the sign fix into a single edge.
module muldiv_div_iter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder
);
  logic [DATA_WIDTH-1:0] quo_q, rem_q;
  logic [DATA_WIDTH:0]   shifted, diff;

  // diff[DATA_WIDTH] set means the trial subtraction went negative: restore.
  assign shifted   = {rem_q, quo_q[DATA_WIDTH-1]};
  assign diff      = shifted - {1'b0, divisor};
  assign remainder = diff[DATA_WIDTH] ? shifted[DATA_WIDTH-1:0] : diff[DATA_WIDTH-1:0];
  assign quotient  = {quo_q[DATA_WIDTH-2:0], ~diff[DATA_WIDTH]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_q <= '0;
      rem_q <= '0;
    end else if (load) begin
      quo_q <= dividend;
      rem_q <= '0;
    end else if (step) begin
      quo_q <= quotient;
      rem_q <= remainder;
    end
  end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide execute unit (stall based).
//   clk, rst  clock, async active-high reset
//   bus       muldiv_if.slave: start/op/rs1_data/rs2_data/rd_in/flush in,
//             busy/done/result/rd_out/we_out out (result/rd/we feed WD3/AD3/WE3)
// Build option: MULDIV_FAST_MUL_EN selects a single-cycle multiplier for
// MUL/MULH/MULHSU/MULHU (IDLE->DONE); otherwise multiplies iterate.
//
// state | meaning
// IDLE  | waiting for start; busy=0
// CALC  | one shift-add / restoring-subtract iteration per cycle
// DONE  | done pulse, result/rd/we valid for one cycle
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5
) (
  input logic     clk,
  input logic     rst,
  muldiv_if.slave bus
);
  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WIDTH - 1);

  typedef logic [DATA_WIDTH-1:0]   word_t;
  typedef logic [2*DATA_WIDTH-1:0] dword_t;

  localparam word_t MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  muldiv_state_e            state;
  muldiv_op_e               op_q;
  logic                     neg_a_q, neg_b_q;
  word_t                    a_mag, b_mag, prod_hi, prod_lo;
  logic [CNT_W-1:0]         count;
  logic                     done_q, we_q;
  word_t                    result_q;
  logic [ADDRESS_WIDTH-1:0] rd_q;

  muldiv_op_e          op_in;
  logic                sa, sb, accept, div_zero, div_ovf, special;
  word_t               mag_a, mag_b, special_res, final_res, quo_nxt, rem_nxt;
  logic [DATA_WIDTH:0] mul_sum;
  dword_t              mul_next;

  // Picks the requested half after applying the product sign.
  function automatic word_t mul_select(muldiv_op_e o, logic neg, dword_t p);
    dword_t f;
    f = neg ? -p : p;
    return (o == OP_MUL) ? f[DATA_WIDTH-1:0] : f[2*DATA_WIDTH-1:DATA_WIDTH];
  endfunction

  assign op_in  = muldiv_op_e'(bus.op);
  assign sa     = is_signed_a(op_in) & bus.rs1_data[DATA_WIDTH-1];
  assign sb     = is_signed_b(op_in) & bus.rs2_data[DATA_WIDTH-1];
  assign mag_a  = sa ? -bus.rs1_data : bus.rs1_data;
  assign mag_b  = sb ? -bus.rs2_data : bus.rs2_data;
  assign accept = (state == IDLE) & bus.start & ~bus.flush;

  assign div_zero = is_div(op_in) && (bus.rs2_data == '0);
  assign div_ovf  = is_div(op_in) && is_signed_b(op_in) &&
                    (bus.rs1_data == MIN_NEG) && (bus.rs2_data == '1);

`ifdef MULDIV_FAST_MUL_EN
  dword_t fast_prod;
  assign fast_prod = {{DATA_WIDTH{1'b0}}, mag_a} * {{DATA_WIDTH{1'b0}}, mag_b};
  assign special   = div_zero | div_ovf | ~is_div(op_in);
`else
  assign special   = div_zero | div_ovf;
`endif

  always_comb begin
    special_res = '0;
    if (div_zero)
      special_res = is_rem(op_in) ? bus.rs1_data : '1;
    else if (div_ovf)
      special_res = is_rem(op_in) ? '0 : MIN_NEG;
`ifdef MULDIV_FAST_MUL_EN
    else if (!is_div(op_in))
      special_res = mul_select(op_in, sa ^ sb, fast_prod);
`endif
  end

  // Shift-add multiply: {prod_hi,prod_lo} starts as {0,b}; after DATA_WIDTH
  // steps it holds a*b.
  assign mul_sum  = {1'b0, prod_hi} + (prod_lo[0] ? {1'b0, a_mag} : {(DATA_WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, prod_lo[DATA_WIDTH-1:1]};

  muldiv_div_iter #(.DATA_WIDTH(DATA_WIDTH)) u_div (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .step      ((state == CALC) & ~bus.flush),
    .dividend  (mag_a),
    .divisor   (b_mag),
    .quotient  (quo_nxt),
    .remainder (rem_nxt)
  );

  // Remainder follows the dividend's sign; quotient the XOR of both signs.
  always_comb begin
    final_res = '0;
    if (is_rem(op_q))
      final_res = neg_a_q ? -rem_nxt : rem_nxt;
    else if (is_div(op_q))
      final_res = (neg_a_q ^ neg_b_q) ? -quo_nxt : quo_nxt;
    else
      final_res = mul_select(op_q, neg_a_q ^ neg_b_q, mul_next);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      op_q     <= OP_MUL;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      a_mag    <= '0;
      b_mag    <= '0;
      prod_hi  <= '0;
      prod_lo  <= '0;
      count    <= '0;
      done_q   <= 1'b0;
      we_q     <= 1'b0;
      result_q <= '0;
      rd_q     <= '0;
    end else begin
      done_q <= 1'b0;
      we_q   <= 1'b0;
      if (bus.flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (bus.start) begin
            op_q    <= op_in;
            neg_a_q <= sa;
            neg_b_q <= sb;
            a_mag   <= mag_a;
            b_mag   <= mag_b;
            prod_hi <= '0;
            prod_lo <= mag_b;
            count   <= '0;
            rd_q    <= bus.rd_in;
            if (special) begin
              state    <= DONE;
              result_q <= special_res;
              done_q   <= 1'b1;
              we_q     <= (bus.rd_in != '0);
            end else begin
              state <= CALC;
            end
          end
          CALC: begin
            count             <= count + 1'b1;
            {prod_hi, prod_lo} <= mul_next;
            if (count == LAST) begin
              state    <= DONE;
              result_q <= final_res;
              done_q   <= 1'b1;
              we_q     <= (rd_q != '0);
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.busy   = (state != IDLE);
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.rd_out = rd_q;
  assign bus.we_out = we_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit. Expected results come
// from a 64-bit arithmetic reference model, are queued at issue time and
// popped when done pulses.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        we;
    int          lat;
  } exp_t;
  exp_t sb_q[$];

  muldiv_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) bus();

  muldiv_unit #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'b0, a});
    ub  = longint'({32'b0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (op)
      3'd0: p = 64'(ua * ub);
      3'd1: p = 64'(sa * sb);
      3'd2: p = 64'(sa * ub);
      3'd3: p = 64'(ua * ub);
      3'd4: p = (b == 0) ? 64'hFFFF_FFFF : (ovf ? {32'b0, a} : 64'(sa / sb));
      3'd5: p = (b == 0) ? 64'hFFFF_FFFF : 64'(ua / ub);
      3'd6: p = (b == 0) ? {32'b0, a} : (ovf ? 64'd0 : 64'(sa % sb));
      default: p = (b == 0) ? {32'b0, a} : 64'(ua % ub);
    endcase
    if (op inside {3'd1, 3'd2, 3'd3}) return p[63:32];
    return p[31:0];
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op >= 3'd4) begin
      if (b == 0) return 1;
      if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
    end
`ifdef MULDIV_FAST_MUL_EN
    return 1;
`else
    return 33;
`endif
  endfunction

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit push);
    exp_t e;
    if (push) begin
      e.res = model(op, a, b);
      e.rd  = rd;
      e.we  = (rd != 5'd0);
      e.lat = exp_lat(op, a, b);
      sb_q.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.rs1_data = a; bus.rs2_data = b; bus.rd_in = rd;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.op = 3'($urandom); bus.rs1_data = $urandom;
    bus.rs2_data = $urandom; bus.rd_in = 5'($urandom);
  endtask

  task automatic wait_done(input int limit, output logic got, output int cyc, output int busy_cyc,
                           output logic [31:0] res, output logic [4:0] rd, output logic we);
    got = 1'b0; cyc = 0; busy_cyc = 0; res = '0; rd = '0; we = 1'b0;
    while (!got && cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (bus.busy) busy_cyc++;
      if (bus.done) begin
        got = 1'b1; res = bus.result; rd = bus.rd_out; we = bus.we_out;
      end
    end
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] v;
    v = $urandom >> $urandom_range(0, 31);
    if ($urandom_range(0, 1) == 1) v = -v;
    return v;
  endfunction

  task automatic test_reset();
    checks++;
    if ({bus.busy, bus.done, bus.we_out} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl: busy/done/we=%b expected 000", {bus.busy, bus.done, bus.we_out});
    end
    checks++;
    if ({bus.result, bus.rd_out} !== 37'd0) begin
      errors++;
      $display("FAIL reset_data: result=%h rd_out=%0d expected 0/0", bus.result, bus.rd_out);
    end
  endtask

  task automatic test_mul();
    exp_t e; logic got, we; int cyc, bc; logic [31:0] r; logic [4:0] rd;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd3, 1'b1);
      else issue(3'd0, rand_operand(), rand_operand(), 5'($urandom_range(1, 31)), 1'b1);
      wait_done(60, got, cyc, bc, r, rd, we);
      e = sb_q.pop_front();
      checks++;
      if (!got || {r, rd, we} !== {e.res, e.rd, e.we}) begin
        errors++;
        $display("FAIL mul_%0d result: got=%b res=%h rd=%0d we=%b expected res=%h rd=%0d we=%b",
                 i, got, r, rd, we, e.res, e.rd, e.we);
      end
      checks++;
      if (cyc != e.lat || bc != e.lat) begin
        errors++;
        $display("FAIL mul_%0d latency: done at %0d busy for %0d expected %0d", i, cyc, bc, e.lat);
      end
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL mul_after_done: done=%b busy=%b expected 0/0", bus.done, bus.busy);
    end
  endtask

  task automatic test_mulh();
    logic [2:0]  ops [3] = '{3'd3, 3'd1, 3'd2};
    logic [31:0] want[3] = '{32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFF};
    exp_t e; logic got, we; int cyc, bc; logic [31:0] r; logic [4:0] rd;
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 1'b1);
      wait_done(60, got, cyc, bc, r, rd, we);
      e = sb_q.pop_front();
      checks++;
      if (!got || r !== want[i] || r !== e.res) begin
        errors++;
        $display("FAIL mulh_op%0d: got=%b res=%h expected %h", ops[i], got, r, want[i]);
      end
      checks++;
      if (cyc != e.lat || we !== 1'b1) begin
        errors++;
        $display("FAIL mulh_op%0d latency/we: %0d/%b expected %0d/1", ops[i], cyc, we, e.lat);
      end
    end
  endtask

  task automatic test_div();
    logic [2:0]  ops [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
    logic [31:0] av  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    logic [31:0] bv  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] want[4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
    exp_t e; logic got, we; int cyc, bc; logic [31:0] r; logic [4:0] rd;
    for (int i = 0; i < 10; i++) begin
      if (i < 4) issue(ops[i], av[i], bv[i], 5'd17, 1'b1);
      else issue(3'($urandom_range(4, 7)), rand_operand(), rand_operand(), 5'($urandom_range(1, 31)), 1'b1);
      wait_done(60, got, cyc, bc, r, rd, we);
      e = sb_q.pop_front();
      checks++;
      if (!got || r !== e.res || (i < 4 && r !== want[i])) begin
        errors++;
        $display("FAIL div_%0d result: got=%b res=%h expected %h", i, got, r, e.res);
      end
      checks++;
      if (cyc != e.lat || rd !== e.rd) begin
        errors++;
        $display("FAIL div_%0d latency/rd: %0d/%0d expected %0d/%0d", i, cyc, rd, e.lat, e.rd);
      end
    end
  endtask

  task automatic test_special();
    logic [2:0]  ops [4] = '{3'd4, 3'd6, 3'd4, 3'd6};
    logic [31:0] av  [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bv  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] want[4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    exp_t e; logic got, we; int cyc, bc; logic [31:0] r; logic [4:0] rd;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], av[i], bv[i], 5'd1, 1'b1);
      wait_done(60, got, cyc, bc, r, rd, we);
      e = sb_q.pop_front();
      checks++;
      if (!got || r !== want[i] || r !== e.res) begin
        errors++;
        $display("FAIL special_%0d result: got=%b res=%h expected %h", i, got, r, want[i]);
      end
      checks++;
      if (cyc != 1 || bc != 1) begin
        errors++;
        $display("FAIL special_%0d latency: done at %0d busy %0d expected 1/1", i, cyc, bc);
      end
    end
  endtask

  task automatic test_start_ignored();
    exp_t e; logic got, we; int cyc, bc; logic [31:0] r; logic [4:0] rd;
    issue(3'd5, 32'd100, 32'd7, 5'd4, 1'b1);
    repeat (5) @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd4; bus.rs1_data = 32'd5; bus.rs2_data = 32'd0; bus.rd_in = 5'd8;
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done(60, got, cyc, bc, r, rd, we);
    e = sb_q.pop_front();
    checks++;
    if (!got || r !== 32'd14 || rd !== 5'd4) begin
      errors++;
      $display("FAIL start_ignored result: got=%b res=%h rd=%0d expected 0000000e/4", got, r, rd);
    end
    checks++;
    if (cyc != e.lat - 5) begin
      errors++;
      $display("FAIL start_ignored latency: done %0d cycles later expected %0d", cyc, e.lat - 5);
    end
  endtask

  task automatic test_flush();
    exp_t e; logic got, we; int cyc, bc; logic [31:0] r, prev; logic [4:0] rd;
    prev = bus.result;
    issue(3'd5, 32'd1000, 32'd3, 5'd6, 1'b0);
    repeat (10) @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle: busy=%b done=%b expected 0/0", bus.busy, bus.done);
    end
    wait_done(40, got, cyc, bc, r, rd, we);
    checks++;
    if (got || bus.result !== prev) begin
      errors++;
      $display("FAIL flush_no_done: done seen=%b result=%h expected 0/%h", got, bus.result, prev);
    end
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = 3'd5; bus.rs1_data = 32'd9; bus.rs2_data = 32'd3;
    @(posedge clk);
    #1 begin bus.start = 1'b0; bus.flush = 1'b0; end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_over_start: busy=%b expected 0", bus.busy);
    end
    issue(3'd5, 32'd9, 32'd3, 5'd6, 1'b1);
    wait_done(60, got, cyc, bc, r, rd, we);
    e = sb_q.pop_front();
    checks++;
    if (!got || r !== 32'd3 || cyc != e.lat) begin
      errors++;
      $display("FAIL flush_then_divu: got=%b res=%h lat=%0d expected 00000003 lat %0d", got, r, cyc, e.lat);
    end
  endtask

  task automatic test_reset_mid();
    logic got, we; int cyc, bc; logic [31:0] r; logic [4:0] rd;
    issue(3'd0, 32'd123, 32'd456, 5'd2, 1'b0);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.result} !== 34'd0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b result=%h expected 0/0/0", bus.busy, bus.done, bus.result);
    end
    @(negedge clk);
    rst = 1'b0;
    wait_done(40, got, cyc, bc, r, rd, we);
    checks++;
    if (got || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_no_done: done seen=%b busy=%b expected 0/0", got, bus.busy);
    end
  endtask

  task automatic test_rd_zero();
    exp_t e; logic got, we; int cyc, bc; logic [31:0] r; logic [4:0] rd;
    issue(3'd5, 32'd50, 32'd5, 5'd0, 1'b1);
    wait_done(60, got, cyc, bc, r, rd, we);
    e = sb_q.pop_front();
    checks++;
    if (!got || we !== 1'b0 || rd !== 5'd0) begin
      errors++;
      $display("FAIL rd_zero: done=%b we=%b rd=%0d expected 1/0/0", got, we, rd);
    end
    checks++;
    if (r !== e.res) begin
      errors++;
      $display("FAIL rd_zero_result: res=%h expected %h", r, e.res);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e; logic got, we; int cyc, bc; logic [31:0] r; logic [4:0] rd;
    for (int i = 0; i < 6; i++) begin
      issue(3'($urandom_range(0, 7)), rand_operand(), rand_operand(), 5'($urandom_range(0, 31)), 1'b1);
      wait_done(60, got, cyc, bc, r, rd, we);
      e = sb_q.pop_front();
      checks++;
      if (!got || {r, rd, we} !== {e.res, e.rd, e.we}) begin
        errors++;
        $display("FAIL b2b_%0d: got=%b res=%h rd=%0d we=%b expected %h/%0d/%b",
                 i, got, r, rd, we, e.res, e.rd, e.we);
      end
      checks++;
      if (cyc != e.lat) begin
        errors++;
        $display("FAIL b2b_%0d latency: %0d expected %0d", i, cyc, e.lat);
      end
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.flush = 1'b0; bus.op = 3'd0;
    bus.rs1_data = '0; bus.rs2_data = '0; bus.rd_in = '0;
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_mul();
    test_mulh();
    test_div();
    test_special();
    test_start_ignored();
    test_flush();
    test_reset_mid();
    test_rd_zero();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
